dac_spi_tx: RTL and testbench



---
 rtl/synth_pkg.sv | 26 ++
 rtl/sclk_tick_gen.sv | 41 ++++
 rtl/dac_spi_tx.sv | 156 +++++++++++++++
 tb/tb_dac_spi_tx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the synth output path and its DAC serialiser.
package synth_pkg;

  localparam int unsigned FRAME_W   = 24;
  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned CMD_W     = FRAME_W - SAMPLE_W;
  // Wide enough for a half-period of up to 255 cycles.
  localparam int unsigned DIV_W     = 8;
  // Wide enough to index every bit of a frame.
  localparam int unsigned BIT_CNT_W = 5;

  localparam logic [CMD_W-1:0] DAC_CMD = 8'h30;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LDAC
  } dac_state_t;

  // The wire frame is the command byte followed by the sample, MSB first.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [CMD_W-1:0]    cmd,
                                                     input logic [SAMPLE_W-1:0] sample);
    return {cmd, sample};
  endfunction

endpackage

// File: rtl/sclk_tick_gen.sv
// Reloadable down-counter: one-cycle tick at the end of every CLK_DIV-cycle phase while
// enabled; held at the reload value while disabled so each enable starts a fresh phase.
module sclk_tick_gen
  import synth_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [DIV_W-1:0] Reload = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Next count: reload on disable or phase end, otherwise count down.
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = Reload;
    end else if (cnt_q == '0) begin
      cnt_d = Reload;
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= Reload;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/dac_spi_tx.sv
// SPI write-frame serialiser for a single-channel DAC: {CMD, sample} MSB first in mode 0,
// then an active-low LDAC strobe. One sample per frame via valid/ready; busy offers are
// dropped and flagged on a sticky overrun output. All outputs come straight from flops.
module dac_spi_tx
  import synth_pkg::*;
#(
  parameter int unsigned       CLK_DIV = 2,
  parameter logic [CMD_W-1:0]  CMD     = DAC_CMD
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [SAMPLE_W-1:0] i_data,
  input  logic                i_valid,
  output logic                o_ready,
  output logic                o_dac_sclk,
  output logic                o_dac_mosi,
  output logic                o_dac_cs_n,
  output logic                o_dac_ldac_n,
  output logic                o_overrun
);

  localparam logic [BIT_CNT_W-1:0] LastBit = BIT_CNT_W'(FRAME_W - 1);

  dac_state_t           state_q, state_d;
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  // 0: SCLK-low half of the current bit, 1: SCLK-high half.
  logic                 phase_q, phase_d;

  logic ready_q, ready_d;
  logic sclk_q, sclk_d;
  logic mosi_q, mosi_d;
  logic cs_n_q, cs_n_d;
  logic ldac_n_q, ldac_n_d;
  logic overrun_q, overrun_d;

  logic accept;
  logic tick_en;
  logic tick;

  assign accept  = i_valid && ready_q;
  // The phase counter runs through SHIFT and LDAC and restarts on every frame.
  assign tick_en = (state_q != IDLE);

  sclk_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk  (i_clk),
    .rst  (i_rst),
    .en   (tick_en),
    .tick (tick)
  );

  // Next-state and registered-output logic for the frame FSM.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    ready_d   = ready_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    ldac_n_d  = ldac_n_q;
    overrun_d = overrun_q | (i_valid & ~ready_q);

    unique case (state_q)
      IDLE: begin
        ready_d  = 1'b1;
        sclk_d   = 1'b0;
        mosi_d   = 1'b0;
        cs_n_d   = 1'b1;
        ldac_n_d = 1'b1;
        if (accept) begin
          state_d   = SHIFT;
          shreg_d   = build_frame(CMD, i_data);
          bit_cnt_d = LastBit;
          phase_d   = 1'b0;
          ready_d   = 1'b0;
          cs_n_d    = 1'b0;
          mosi_d    = CMD[CMD_W-1];
        end
      end

      SHIFT: begin
        if (tick) begin
          if (!phase_q) begin
            phase_d = 1'b1;
            sclk_d  = 1'b1;
          end else begin
            // Falling SCLK edge: present the next bit or close the frame.
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            if (bit_cnt_q != '0) begin
              shreg_d   = {shreg_q[FRAME_W-2:0], 1'b0};
              bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
              mosi_d    = shreg_q[FRAME_W-2];
            end else begin
              state_d  = LDAC;
              mosi_d   = 1'b0;
              cs_n_d   = 1'b1;
              ldac_n_d = 1'b0;
            end
          end
        end
      end

      LDAC: begin
        if (tick) begin
          state_d  = IDLE;
          ldac_n_d = 1'b1;
          ready_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight without an LDAC pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      phase_q   <= 1'b0;
      ready_q   <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      ldac_n_q  <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      ready_q   <= ready_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      ldac_n_q  <= ldac_n_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_dac_sclk   = sclk_q;
  assign o_dac_mosi   = mosi_q;
  assign o_dac_cs_n   = cs_n_q;
  assign o_dac_ldac_n = ldac_n_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: three instances (D = 1, 2, 255) on one clock, each cycle of a
// frame compared against pin values computed from the frame timing formulae.
module tb_dac_spi_tx;

  localparam int unsigned N  = 3;
  localparam int unsigned D0 = 1;
  localparam int unsigned D1 = 2;
  localparam int unsigned D2 = 255;

  // Pin vector layout: {ready, sclk, mosi, cs_n, ldac_n, overrun}
  localparam logic [5:0] RstVec  = 6'b000110;
  localparam logic [5:0] AllBits = 6'b111111;

  logic        clk;
  logic        rst    [N];
  logic        valid  [N];
  logic [15:0] data   [N];
  logic        ready  [N];
  logic        sclk   [N];
  logic        mosi   [N];
  logic        cs_n   [N];
  logic        ldac_n [N];
  logic        ovr    [N];

  logic        ovr_m  [N];
  int unsigned n_cmp;
  int unsigned n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dac_spi_tx #(.CLK_DIV(D0), .CMD(8'h30)) u_d1 (
    .i_clk(clk), .i_rst(rst[0]), .i_data(data[0]), .i_valid(valid[0]), .o_ready(ready[0]),
    .o_dac_sclk(sclk[0]), .o_dac_mosi(mosi[0]), .o_dac_cs_n(cs_n[0]),
    .o_dac_ldac_n(ldac_n[0]), .o_overrun(ovr[0])
  );

  dac_spi_tx #(.CLK_DIV(D1), .CMD(8'h30)) u_d2 (
    .i_clk(clk), .i_rst(rst[1]), .i_data(data[1]), .i_valid(valid[1]), .o_ready(ready[1]),
    .o_dac_sclk(sclk[1]), .o_dac_mosi(mosi[1]), .o_dac_cs_n(cs_n[1]),
    .o_dac_ldac_n(ldac_n[1]), .o_overrun(ovr[1])
  );

  dac_spi_tx #(.CLK_DIV(D2), .CMD(8'h30)) u_d255 (
    .i_clk(clk), .i_rst(rst[2]), .i_data(data[2]), .i_valid(valid[2]), .o_ready(ready[2]),
    .o_dac_sclk(sclk[2]), .o_dac_mosi(mosi[2]), .o_dac_cs_n(cs_n[2]),
    .o_dac_ldac_n(ldac_n[2]), .o_overrun(ovr[2])
  );

  function automatic int unsigned div_of(input int idx);
    if (idx == 0) return D0;
    if (idx == 1) return D1;
    return D2;
  endfunction

  function automatic logic [5:0] obs_vec(input int idx);
    return {ready[idx], sclk[idx], mosi[idx], cs_n[idx], ldac_n[idx], ovr[idx]};
  endfunction

  function automatic logic [5:0] idle_vec(input int idx);
    return {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, ovr_m[idx]};
  endfunction

  // Expected pins in cycle T+n after an accept at edge T, from the frame timing rules.
  function automatic logic [5:0] frame_exp(input int unsigned d, input logic [23:0] fr,
                                           input int unsigned n, input logic ov);
    int unsigned k;
    int unsigned ph;
    if (n <= 48 * d) begin
      k  = (n - 1) / (2 * d);
      ph = (n - 1) % (2 * d);
      return {1'b0, (ph >= d), fr[23 - k], 1'b0, 1'b1, ov};
    end else if (n <= 49 * d) begin
      return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ov};
    end
    return {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, ov};
  endfunction

  task automatic check_vec(input string tag, input int idx, input logic [5:0] exp,
                           input logic [5:0] mask, output bit ok);
    logic [5:0] obs;
    obs = obs_vec(idx) & mask;
    n_cmp++;
    ok = 1'b1;
    assert (obs === (exp & mask)) else begin
      n_fail++;
      ok = 1'b0;
      $error("FAIL %s inst%0d t=%0t: observed %b expected %b", tag, idx, $time, obs,
             exp & mask);
    end
  endtask

  task automatic idle_cycles(input int idx, input int unsigned cycles);
    bit ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ok) check_vec("idle", idx, idle_vec(idx), AllBits, ok);
    end
  endtask

  // Called just after a negedge while the instance is ready; returns just after edge T.
  task automatic start_frame(input int idx, input logic [15:0] s);
    valid[idx] = 1'b1;
    data[idx]  = s;
    @(posedge clk);
    #1;
    valid[idx] = 1'b0;
  endtask

  // Checks cycles T+1 .. T+n_max (whole frame when n_max is 0).
  task automatic check_frame(input int idx, input logic [23:0] fr, input int unsigned n_max,
                             input bit scramble);
    int unsigned d;
    int unsigned last;
    int unsigned cs_low;
    logic [23:0] got;
    logic        prev_sclk;
    logic [5:0]  exp;
    logic [5:0]  mask;
    bit          ok;
    d         = div_of(idx);
    last      = 49 * d + 1;
    cs_low    = 0;
    got       = '0;
    prev_sclk = 1'b0;
    ok        = 1'b1;
    if (n_max == 0 || n_max > last) n_max = last;
    for (int unsigned n = 1; n <= n_max; n++) begin
      @(negedge clk);
      exp  = frame_exp(d, fr, n, ovr_m[idx]);
      // MOSI is don't-care while LDAC is low.
      mask = (n > 48 * d && n <= 49 * d) ? 6'b110111 : AllBits;
      if (ok) check_vec("frame", idx, exp, mask, ok);
      if (cs_n[idx] == 1'b0) cs_low++;
      if (sclk[idx] && !prev_sclk) got = {got[22:0], mosi[idx]};
      prev_sclk = sclk[idx];
      if (valid[idx] && !exp[5]) ovr_m[idx] = 1'b1;
      if (scramble) data[idx] = 16'($urandom);
    end
    if (n_max == last) begin
      n_cmp++;
      assert (got === fr) else begin
        n_fail++;
        $error("FAIL mosi_at_rise inst%0d: observed %h expected %h", idx, got, fr);
      end
      n_cmp++;
      assert (cs_low === 48 * d) else begin
        n_fail++;
        $error("FAIL cs_low_cycles inst%0d: observed %0d expected %0d", idx, cs_low, 48 * d);
      end
    end
  endtask

  initial begin
    logic [15:0] s;
    bit          ok;
    n_cmp  = 0;
    n_fail = 0;
    for (int i = 0; i < N; i++) begin
      rst[i]   = 1'b1;
      valid[i] = 1'b0;
      data[i]  = '0;
      ovr_m[i] = 1'b0;
    end

    // Reset values, then ready rising on the first edge after release.
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) check_vec("reset", i, RstVec, AllBits, ok);
    for (int i = 0; i < N; i++) rst[i] = 1'b0;
    #1;
    for (int i = 0; i < N; i++) check_vec("released", i, RstVec, AllBits, ok);
    @(negedge clk);
    for (int i = 0; i < N; i++) check_vec("ready_rise", i, idle_vec(i), AllBits, ok);

    // D=2 directed frame.
    start_frame(1, 16'hA5C3);
    check_frame(1, 24'h30A5C3, 0, 1'b0);

    // D=2 random frames with random gaps (gap 0 exercises the no-bubble accept).
    for (int i = 0; i < 4; i++) begin
      s = 16'($urandom);
      idle_cycles(1, $urandom_range(0, 4));
      start_frame(1, s);
      check_frame(1, {8'h30, s}, 0, 1'b0);
    end

    // i_data scrambled every cycle of the frame.
    start_frame(1, 16'h8000);
    check_frame(1, 24'h308000, 0, 1'b1);
    data[1] = '0;

    // D=1 back-to-back with i_valid held high.
    valid[0] = 1'b1;
    data[0]  = 16'h0000;
    @(posedge clk);
    #1;
    data[0] = 16'hFFFF;
    check_frame(0, 24'h300000, 0, 1'b0);
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    check_frame(0, 24'h30FFFF, 0, 1'b0);
    idle_cycles(0, 5);

    // D=255 single random frame.
    s = 16'($urandom);
    start_frame(2, s);
    check_frame(2, {8'h30, s}, 0, 1'b0);

    // Reset mid-frame after bit 10 (D=2), then a clean frame.
    s = 16'($urandom);
    start_frame(1, s);
    check_frame(1, {8'h30, s}, 44, 1'b0);
    rst[1]   = 1'b1;
    ovr_m[1] = 1'b0;
    #1;
    check_vec("async_reset", 1, RstVec, AllBits, ok);
    repeat (4) begin
      @(negedge clk);
      check_vec("held_reset", 1, RstVec, AllBits, ok);
    end
    rst[1] = 1'b0;
    #1;
    check_vec("release_mid", 1, RstVec, AllBits, ok);
    @(negedge clk);
    check_vec("ready_after_mid", 1, idle_vec(1), AllBits, ok);
    start_frame(1, 16'h1234);
    check_frame(1, 24'h301234, 0, 1'b0);

    // Long idle: pins static and overrun stays clear.
    idle_cycles(1, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
